// File: rtl/scope_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scope_axil_pkg
// Description : Shared definitions for the scope AXI4-Lite register block:
//               register indices, response code and FSM state types.
// Revision    : 1.0 - initial release
// ============================================================================
package scope_axil_pkg;

    localparam int          NUM_REGS  = 4;

    localparam logic [1:0]  REG_CTRL  = 2'd0;
    localparam logic [1:0]  REG_TRIG  = 2'd1;
    localparam logic [1:0]  REG_TBASE = 2'd2;
    localparam logic [1:0]  REG_AUX   = 2'd3;

    localparam logic [1:0]  RESP_OKAY = 2'b00;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage : scope_axil_pkg
`default_nettype wire

// File: rtl/scope_axil_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : scope_axil_regs_if
// Description : AXI4-Lite bus bundle between a master and the scope register
//               block. master modport drives requests, slave drives replies.
// Revision    : 1.0 - initial release
// ============================================================================
interface scope_axil_regs_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr;
    logic [2:0]                        s00_axi_awprot;
    logic                              s00_axi_awvalid;
    logic                              s00_axi_awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb;
    logic                              s00_axi_wvalid;
    logic                              s00_axi_wready;
    logic [1:0]                        s00_axi_bresp;
    logic                              s00_axi_bvalid;
    logic                              s00_axi_bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr;
    logic [2:0]                        s00_axi_arprot;
    logic                              s00_axi_arvalid;
    logic                              s00_axi_arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata;
    logic [1:0]                        s00_axi_rresp;
    logic                              s00_axi_rvalid;
    logic                              s00_axi_rready;

    modport master (
        output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        input  s00_axi_awready,
        output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        input  s00_axi_wready,
        input  s00_axi_bresp, s00_axi_bvalid,
        output s00_axi_bready,
        output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        input  s00_axi_arready,
        input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        output s00_axi_rready
    );

    modport slave (
        input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        output s00_axi_awready,
        input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
        output s00_axi_wready,
        output s00_axi_bresp, s00_axi_bvalid,
        input  s00_axi_bready,
        input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
        output s00_axi_arready,
        output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        input  s00_axi_rready
    );

endinterface : scope_axil_regs_if
`default_nettype wire

// File: rtl/scope_axil_wrch.sv
`default_nettype none
// ============================================================================
// Module      : scope_axil_wrch
// Description : Joins the AXI4-Lite write-address and write-data channels.
//               Each beat is latched independently; its ready stays low while
//               latched and reopens in the cycle the write response completes.
// Ports       : clk, rst            - clock, async active-high reset
//               i_aw*, o_awready    - write-address channel (index only)
//               i_w*,  o_wready     - write-data channel
//               i_b_done            - B handshake of the current write
//               o_aw_held/o_w_held  - beat latched flags
//               o_idx/o_data/o_strb - latched write request
// Revision    : 1.0 - initial release
// ============================================================================
module scope_axil_wrch #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic [1:0]              i_awidx,
    input  wire logic                    i_awvalid,
    output logic                         o_awready,
    input  wire logic [DATA_WIDTH-1:0]   i_wdata,
    input  wire logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  wire logic                    i_wvalid,
    output logic                         o_wready,
    input  wire logic                    i_b_done,
    output logic                         o_aw_held,
    output logic                         o_w_held,
    output logic [1:0]                   o_idx,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic [DATA_WIDTH/8-1:0]      o_strb
);

    // Held low through reset so no ready is visible until the first edge.
    logic r_en;
    logic r_aw_held;
    logic r_w_held;
    logic w_aw_hs;
    logic w_w_hs;

    // Readiness returns in the response-completion cycle so a held-high
    // bready sustains one write every two cycles.
    assign o_awready = r_en && (!r_aw_held || i_b_done);
    assign o_wready  = r_en && (!r_w_held  || i_b_done);
    assign w_aw_hs   = i_awvalid && o_awready;
    assign w_w_hs    = i_wvalid  && o_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            o_idx     <= '0;
            o_data    <= '0;
            o_strb    <= '0;
        end else begin
            r_en <= 1'b1;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                o_idx     <= i_awidx;
            end else if (i_b_done) begin
                r_aw_held <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                o_data   <= i_wdata;
                o_strb   <= i_wstrb;
            end else if (i_b_done) begin
                r_w_held <= 1'b0;
            end
        end
    end

    assign o_aw_held = r_aw_held;
    assign o_w_held  = r_w_held;

endmodule : scope_axil_wrch
`default_nettype wire

// File: rtl/scope_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : scope_axil_regs
// Description : Four 32-bit AXI4-Lite control registers for the scope core,
//               with independent write and read FSMs. All accesses respond
//               OKAY; the register index is address bits [3:2].
// Ports       : s00_axi_aclk   - clock (rising edge)
//               s00_axi_areset - asynchronous active-high reset
//               s_axi          - AXI4-Lite slave bundle
//               reg0_o..reg3_o - register contents
//               reg_wr_o       - one-hot pulse in the cycle a register updates
// Revision    : 1.0 - initial release
// ============================================================================
module scope_axil_regs
    import scope_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,  // only 32 is supported
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  wire logic                          s00_axi_aclk,
    input  wire logic                          s00_axi_areset,
    scope_axil_regs_if.slave                   s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      reg3_o,
    output logic [NUM_REGS-1:0]                reg_wr_o
);

    localparam int c_strb_w = C_S_AXI_DATA_WIDTH / 8;
    localparam int c_ai_msb = C_S_AXI_ADDR_WIDTH - 1;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [NUM_REGS];
    wr_state_t                     r_wstate;
    rd_state_t                     r_rstate;
    logic                          r_bvalid;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic                          r_rd_en;

    logic                          w_aw_held;
    logic                          w_w_held;
    logic [1:0]                    w_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
    logic [c_strb_w-1:0]           w_strb;
    logic                          w_b_done;
    logic                          w_do_write;
    logic                          w_ar_hs;
    logic                          w_unused_ok;

    // Protection bits and byte offset carry no meaning for this block.
    assign w_unused_ok = &{1'b0, s_axi.s00_axi_awprot, s_axi.s00_axi_arprot,
                           s_axi.s00_axi_awaddr[1:0], s_axi.s00_axi_araddr[1:0]};

    // ------------------------------------------------------------------ write
    assign w_b_done   = r_bvalid && s_axi.s00_axi_bready;
    assign w_do_write = (r_wstate == W_IDLE) && w_aw_held && w_w_held;

    scope_axil_wrch #(
        .DATA_WIDTH (C_S_AXI_DATA_WIDTH)
    ) u_wrch (
        .clk       (s00_axi_aclk),
        .rst       (s00_axi_areset),
        .i_awidx   (s_axi.s00_axi_awaddr[c_ai_msb:2]),
        .i_awvalid (s_axi.s00_axi_awvalid),
        .o_awready (s_axi.s00_axi_awready),
        .i_wdata   (s_axi.s00_axi_wdata),
        .i_wstrb   (s_axi.s00_axi_wstrb),
        .i_wvalid  (s_axi.s00_axi_wvalid),
        .o_wready  (s_axi.s00_axi_wready),
        .i_b_done  (w_b_done),
        .o_aw_held (w_aw_held),
        .o_w_held  (w_w_held),
        .o_idx     (w_idx),
        .o_data    (w_data),
        .o_strb    (w_strb)
    );

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_wstate <= W_IDLE;
            r_bvalid <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_do_write) begin
                        r_wstate <= W_RESP;
                        r_bvalid <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi.s00_axi_bready) begin
                        r_wstate <= W_IDLE;
                        r_bvalid <= 1'b0;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // The pulse marks the cycle whose closing edge updates the register.
    always_comb begin
        reg_wr_o = '0;
        if (w_do_write) reg_wr_o[w_idx] = 1'b1;
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_do_write) begin
            for (int b = 0; b < c_strb_w; b++) begin
                if (w_strb[b]) r_regs[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
    end

    assign s_axi.s00_axi_bvalid = r_bvalid;
    assign s_axi.s00_axi_bresp  = RESP_OKAY;

    // ------------------------------------------------------------------- read
    assign s_axi.s00_axi_arready = r_rd_en && (r_rstate == R_IDLE);
    assign w_ar_hs = s_axi.s00_axi_arvalid && s_axi.s00_axi_arready;

    // Captures with the same edge that may write, so rdata is the old value.
    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            r_rd_en  <= 1'b0;
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rd_en <= 1'b1;
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata  <= r_regs[s_axi.s00_axi_araddr[c_ai_msb:2]];
                        r_rvalid <= 1'b1;
                        r_rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.s00_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.s00_axi_rvalid = r_rvalid;
    assign s_axi.s00_axi_rdata  = r_rdata;
    assign s_axi.s00_axi_rresp  = RESP_OKAY;

    assign reg0_o = r_regs[REG_CTRL];
    assign reg1_o = r_regs[REG_TRIG];
    assign reg2_o = r_regs[REG_TBASE];
    assign reg3_o = r_regs[REG_AUX];

endmodule : scope_axil_regs
`default_nettype wire

// File: tb/tb_scope_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_scope_axil_regs
// Description : Self-checking bench for scope_axil_regs. A transaction-level
//               model tracks accepted beats and register contents; a negedge
//               monitor compares the DUT against it every cycle, and directed
//               sequences pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scope_axil_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dut_reg [4];
    logic [3:0]  reg_wr;

    always #5 clk = ~clk;

    scope_axil_regs_if bus ();

    scope_axil_regs dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s_axi          (bus),
        .reg0_o         (dut_reg[0]),
        .reg1_o         (dut_reg[1]),
        .reg2_o         (dut_reg[2]),
        .reg3_o         (dut_reg[3]),
        .reg_wr_o       (reg_wr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [31:0] m_regs [4];
    logic [1:0]  aw_q [$];
    logic [35:0] w_q [$];
    logic [31:0] r_q [$];
    int  aw_out, w_out, ar_out, b_pend;
    int  cyc = 0;
    int  pulse_cnt [4];
    int  pulse_cyc [$];
    int  b_hs_cnt = 0;
    bit  want_pulse, prev_pulse, prev_ar_hs, prev_bhold, prev_rhold;
    bit  prev_rst = 1'b1;
    logic [31:0] prev_rdata;

    always @(negedge clk) begin : mon
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [1:0]  idx;
        logic [35:0] wb;
        cyc++;
        if (rst) begin
            for (int i = 0; i < 4; i++) chk("rst_reg", dut_reg[i], 32'h0);
            chk("rst_reg_wr",  {28'h0, reg_wr}, 32'h0);
            chk("rst_bvalid",  {31'h0, bus.s00_axi_bvalid}, 32'h0);
            chk("rst_rvalid",  {31'h0, bus.s00_axi_rvalid}, 32'h0);
            chk("rst_rdata",   bus.s00_axi_rdata, 32'h0);
            chk("rst_awready", {31'h0, bus.s00_axi_awready}, 32'h0);
            chk("rst_wready",  {31'h0, bus.s00_axi_wready}, 32'h0);
            chk("rst_arready", {31'h0, bus.s00_axi_arready}, 32'h0);
            for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
            aw_q.delete(); w_q.delete(); r_q.delete();
            aw_out = 0; w_out = 0; ar_out = 0; b_pend = 0;
            want_pulse = 0; prev_pulse = 0; prev_ar_hs = 0;
            prev_bhold = 0; prev_rhold = 0; prev_rst = 1'b1;
        end else begin
            aw_hs = bus.s00_axi_awvalid && bus.s00_axi_awready;
            w_hs  = bus.s00_axi_wvalid  && bus.s00_axi_wready;
            b_hs  = bus.s00_axi_bvalid  && bus.s00_axi_bready;
            ar_hs = bus.s00_axi_arvalid && bus.s00_axi_arready;
            r_hs  = bus.s00_axi_rvalid  && bus.s00_axi_rready;

            for (int i = 0; i < 4; i++) chk("reg_value", dut_reg[i], m_regs[i]);

            if (!prev_rst) begin
                if (aw_out == 0) chk("awready_idle", {31'h0, bus.s00_axi_awready}, 32'h1);
                else if (!b_hs)  chk("awready_held", {31'h0, bus.s00_axi_awready}, 32'h0);
                if (w_out == 0)  chk("wready_idle",  {31'h0, bus.s00_axi_wready}, 32'h1);
                else if (!b_hs)  chk("wready_held",  {31'h0, bus.s00_axi_wready}, 32'h0);
                chk("arready", {31'h0, bus.s00_axi_arready}, (ar_out == 0) ? 32'h1 : 32'h0);
            end
            if (want_pulse) chk("wr_pulse_missing", {31'h0, reg_wr != 4'h0}, 32'h1);
            if (prev_pulse) chk("bvalid_rise", {31'h0, bus.s00_axi_bvalid}, 32'h1);
            if (prev_ar_hs) chk("rvalid_rise", {31'h0, bus.s00_axi_rvalid}, 32'h1);
            if (prev_bhold) chk("bvalid_hold", {31'h0, bus.s00_axi_bvalid}, 32'h1);
            if (prev_rhold) begin
                chk("rvalid_hold", {31'h0, bus.s00_axi_rvalid}, 32'h1);
                chk("rdata_hold",  bus.s00_axi_rdata, prev_rdata);
            end
            if (bus.s00_axi_bvalid) chk("bvalid_spurious", {31'h0, b_pend > 0}, 32'h1);
            if (bus.s00_axi_rvalid) chk("rvalid_spurious", {31'h0, ar_out > 0}, 32'h1);

            // Read sees register contents before any write landing this cycle.
            if (r_hs) begin
                chk("rresp", {30'h0, bus.s00_axi_rresp}, 32'h0);
                if (r_q.size() > 0) chk("rdata", bus.s00_axi_rdata, r_q.pop_front());
                else chk("r_unexpected", 32'h1, 32'h0);
                ar_out--;
            end
            if (ar_hs) begin
                r_q.push_back(m_regs[bus.s00_axi_araddr[3:2]]);
                ar_out++;
            end

            if (reg_wr != 4'h0) begin
                for (int i = 0; i < 4; i++) if (reg_wr[i]) pulse_cnt[i]++;
                pulse_cyc.push_back(cyc);
                if (aw_q.size() > 0 && w_q.size() > 0) begin
                    idx = aw_q.pop_front();
                    wb  = w_q.pop_front();
                    chk("reg_wr_onehot", {28'h0, reg_wr}, 32'h1 << idx);
                    for (int b = 0; b < 4; b++)
                        if (wb[32+b]) m_regs[idx][b*8 +: 8] = wb[b*8 +: 8];
                    b_pend++;
                end else begin
                    chk("wr_unexpected", {28'h0, reg_wr}, 32'h0);
                end
            end

            if (b_hs) begin
                chk("bresp", {30'h0, bus.s00_axi_bresp}, 32'h0);
                b_hs_cnt++;
                b_pend--; aw_out--; w_out--;
            end
            if (aw_hs) begin aw_q.push_back(bus.s00_axi_awaddr[3:2]); aw_out++; end
            if (w_hs)  begin w_q.push_back({bus.s00_axi_wstrb, bus.s00_axi_wdata}); w_out++; end

            want_pulse = (aw_q.size() > 0) && (w_q.size() > 0);
            prev_pulse = (reg_wr != 4'h0);
            prev_ar_hs = ar_hs;
            prev_bhold = bus.s00_axi_bvalid && !bus.s00_axi_bready;
            prev_rhold = bus.s00_axi_rvalid && !bus.s00_axi_rready;
            prev_rdata = bus.s00_axi_rdata;
            prev_rst   = 1'b0;
        end
    end

    // -------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_aw(input logic [3:0] a);
        bit ok = 0;
        bus.s00_axi_awaddr = a; bus.s00_axi_awvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.s00_axi_awready) begin ok = 1; break; end
        end
        if (!ok) chk("aw_timeout", 32'h0, 32'h1);
        tick();
        bus.s00_axi_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        bus.s00_axi_wdata = d; bus.s00_axi_wstrb = s; bus.s00_axi_wvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.s00_axi_wready) begin ok = 1; break; end
        end
        if (!ok) chk("w_timeout", 32'h0, 32'h1);
        tick();
        bus.s00_axi_wvalid = 1'b0;
    endtask

    task automatic wait_bvalid(input bit need_ready);
        bit ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.s00_axi_bvalid && (bus.s00_axi_bready || !need_ready)) begin ok = 1; break; end
        end
        if (!ok) chk("b_timeout", 32'h0, 32'h1);
        tick();
    endtask

    task automatic write_txn(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            do_aw(a);
            do_w(d, s);
        join
        wait_bvalid(1'b1);
    endtask

    task automatic do_ar(input logic [3:0] a);
        bit ok = 0;
        bus.s00_axi_araddr = a; bus.s00_axi_arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.s00_axi_arready) begin ok = 1; break; end
        end
        if (!ok) chk("ar_timeout", 32'h0, 32'h1);
        tick();
        bus.s00_axi_arvalid = 1'b0;
    endtask

    task automatic read_txn(input logic [3:0] a, output logic [31:0] d);
        bit ok = 0;
        do_ar(a);
        d = 32'hx;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.s00_axi_rvalid && bus.s00_axi_rready) begin
                ok = 1; d = bus.s00_axi_rdata; break;
            end
        end
        if (!ok) chk("r_timeout", 32'h0, 32'h1);
        tick();
    endtask

    // ------------------------------------------------------------- sequence
    initial begin : main
        logic [31:0] d;
        int p, bc;
        rst = 1'b1;
        bus.s00_axi_awaddr = '0; bus.s00_axi_awprot = '0; bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wdata  = '0; bus.s00_axi_wstrb  = '0; bus.s00_axi_wvalid  = 1'b0;
        bus.s00_axi_bready = 1'b1;
        bus.s00_axi_araddr = '0; bus.s00_axi_arprot = '0; bus.s00_axi_arvalid = 1'b0;
        bus.s00_axi_rready = 1'b1;
        for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        @(negedge clk);
        chk("ready_after_rst_aw", {31'h0, bus.s00_axi_awready}, 32'h1);
        chk("ready_after_rst_w",  {31'h0, bus.s00_axi_wready},  32'h1);
        chk("ready_after_rst_ar", {31'h0, bus.s00_axi_arready}, 32'h1);
        chk("reset_reg2", dut_reg[2], 32'h0);
        tick();

        // Basic write then read of every register.
        for (int i = 0; i < 4; i++) write_txn(4'(i * 4), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) begin
            read_txn(4'(i * 4), d);
            chk("basic_read", d, 32'(i + 1));
        end

        // Byte-strobed write.
        write_txn(4'h4, 32'h11223344, 4'hF);
        p = pulse_cnt[1];
        write_txn(4'h4, 32'hAABBCCDD, 4'b0101);
        chk("strb_pulse_count", 32'(pulse_cnt[1] - p), 32'h1);
        chk("strb_reg1", dut_reg[1], 32'h11BB33DD);
        read_txn(4'h4, d);
        chk("strb_read", d, 32'h11BB33DD);

        // Zero strobe still responds and pulses but changes nothing.
        p = pulse_cnt[2];
        write_txn(4'hA, 32'hFFFFFFFF, 4'h0);
        chk("strb0_pulse_count", 32'(pulse_cnt[2] - p), 32'h1);
        read_txn(4'h8, d);
        chk("strb0_read", d, 32'h3);

        // Data beat ahead of address, then address ahead of data.
        bc = b_hs_cnt;
        do_w(32'h55, 4'hF);
        @(negedge clk);
        chk("early_w_wready_low", {31'h0, bus.s00_axi_wready}, 32'h0);
        chk("early_w_awready_high", {31'h0, bus.s00_axi_awready}, 32'h1);
        tick(); tick();
        do_aw(4'h0);
        wait_bvalid(1'b1);
        do_aw(4'hC);
        @(negedge clk);
        chk("early_aw_awready_low", {31'h0, bus.s00_axi_awready}, 32'h0);
        chk("early_aw_wready_high", {31'h0, bus.s00_axi_wready}, 32'h1);
        tick(); tick();
        do_w(32'h66, 4'hF);
        wait_bvalid(1'b1);
        chk("split_b_count", 32'(b_hs_cnt - bc), 32'h2);
        read_txn(4'h0, d); chk("w_first_read", d, 32'h55);
        read_txn(4'hC, d); chk("aw_first_read", d, 32'h66);

        // Read capturing a register in its write cycle returns the old value.
        fork
            write_txn(4'hC, 32'hDEADBEEF, 4'hF);
            begin tick(); read_txn(4'hC, d); end
        join
        chk("collide_read_old", d, 32'h66);
        read_txn(4'hC, d);
        chk("collide_read_new", d, 32'hDEADBEEF);

        // Response back-pressure.
        bus.s00_axi_bready = 1'b0;
        fork do_aw(4'h0); do_w(32'h77, 4'hF); join
        wait_bvalid(1'b0);
        bus.s00_axi_awaddr = 4'h4; bus.s00_axi_awvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bstall_bvalid",  {31'h0, bus.s00_axi_bvalid},  32'h1);
            chk("bstall_awready", {31'h0, bus.s00_axi_awready}, 32'h0);
            tick();
        end
        bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_bready  = 1'b1;
        wait_bvalid(1'b1);

        bus.s00_axi_rready = 1'b0;
        do_ar(4'h0);
        bus.s00_axi_araddr = 4'h4; bus.s00_axi_arvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rstall_rvalid",  {31'h0, bus.s00_axi_rvalid},  32'h1);
            chk("rstall_rdata",   bus.s00_axi_rdata, 32'h77);
            chk("rstall_arready", {31'h0, bus.s00_axi_arready}, 32'h0);
            tick();
        end
        bus.s00_axi_arvalid = 1'b0;
        bus.s00_axi_rready  = 1'b1;
        tick(); tick();

        // Streaming writes with bready held high: one write every 2 cycles.
        bus.s00_axi_awaddr = 4'h0; bus.s00_axi_wdata = 32'hA0; bus.s00_axi_wstrb = 4'hF;
        bus.s00_axi_awvalid = 1'b1; bus.s00_axi_wvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bit ok = 0;
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (bus.s00_axi_awready && bus.s00_axi_wready) begin ok = 1; break; end
            end
            if (!ok) chk("stream_timeout", 32'h0, 32'h1);
            tick();
            bus.s00_axi_awaddr = 4'((k + 1) * 4);
            bus.s00_axi_wdata  = 32'hA1 + 32'(k);
        end
        bus.s00_axi_awvalid = 1'b0; bus.s00_axi_wvalid = 1'b0;
        repeat (4) tick();
        p = pulse_cyc.size();
        if (p >= 3) begin
            chk("stream_gap_1", 32'(pulse_cyc[p-2] - pulse_cyc[p-3]), 32'h2);
            chk("stream_gap_2", 32'(pulse_cyc[p-1] - pulse_cyc[p-2]), 32'h2);
        end else begin
            chk("stream_pulses", 32'(p), 32'h3);
        end
        read_txn(4'h8, d); chk("stream_read_2", d, 32'hA2);
        read_txn(4'h4, d); chk("stream_read_1", d, 32'hA1);

        // Reset while a response is pending.
        bus.s00_axi_bready = 1'b0;
        fork do_aw(4'h0); do_w(32'h5, 4'hF); join
        wait_bvalid(1'b0);
        chk("pre_rst_reg0", dut_reg[0], 32'h5);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_bvalid_drop", {31'h0, bus.s00_axi_bvalid}, 32'h0);
        chk("rst_reg0_clear", dut_reg[0], 32'h0);
        bc = b_hs_cnt;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        bus.s00_axi_bready = 1'b1;
        repeat (6) tick();
        chk("no_b_after_rst", 32'(b_hs_cnt - bc), 32'h0);
        write_txn(4'h4, 32'h9, 4'hF);
        read_txn(4'h4, d);
        chk("post_rst_read", d, 32'h9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule : tb_scope_axil_regs
`default_nettype wire
